// File: rtl/decode_ctrl_pipe.sv
// Registered MIPS main-control decode stage with an ID/EX handshake register and MULT/DIV occupancy tracking.
// Optional build macro RI_EXCEPT_EN: flags reserved instructions on ex_ri and zeroes their control bundle.
module decode_ctrl_pipe #(
  parameter int ALUOP_W    = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        id_instr,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic               flush,
  input  logic               ex_ready,
  output logic               ex_valid,
  output logic               ex_regwrite,
  output logic               ex_regdst,
  output logic               ex_branch,
  output logic               ex_memwrite,
  output logic               ex_memtoreg,
  output logic               ex_jump,
  output logic               ex_bal,
  output logic [1:0]         ex_alusrc,
  output logic [1:0]         ex_hilowrite,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic               md_busy,
  output logic               ex_ri
);

  localparam int MAXC  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = (MAXC < 1) ? 1 : $clog2(MAXC + 1);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_R     = 4'd1;
  localparam logic [3:0] OP_ADDI  = 4'd2;
  localparam logic [3:0] OP_ADDIU = 4'd3;
  localparam logic [3:0] OP_SLTI  = 4'd4;
  localparam logic [3:0] OP_SLTIU = 4'd5;
  localparam logic [3:0] OP_ANDI  = 4'd6;
  localparam logic [3:0] OP_ORI   = 4'd7;
  localparam logic [3:0] OP_XORI  = 4'd8;
  localparam logic [3:0] OP_LUI   = 4'd9;
  localparam logic [3:0] OP_MEM   = 4'd10;
  localparam logic [3:0] OP_BR    = 4'd11;

  typedef struct packed {
    logic       regwrite;
    logic       regdst;
    logic       branch;
    logic       memwrite;
    logic       memtoreg;
    logic       jump;
    logic       bal;
    logic [1:0] alusrc;
    logic [1:0] hilowrite;
    logic [3:0] aluop;
  } ctrl_t;

  logic [5:0] op, funct;
  logic [4:0] rt;
  assign op    = id_instr[31:26];
  assign rt    = id_instr[20:16];
  assign funct = id_instr[5:0];

  logic unused_instr;
  assign unused_instr = ^{id_instr[25:21], id_instr[15:6]};

  ctrl_t      raw, dec, ex_q;
  logic       bad_op, bad_funct, dec_ri;
  logic [CNT_W-1:0] cnt;
  logic       hilo_user, is_mul, is_div, accept;

  always_comb begin
    raw       = '0;
    bad_op    = 1'b0;
    bad_funct = 1'b0;
    case (op)
      6'b000000: begin
        raw.regwrite = 1'b1;
        raw.regdst   = 1'b1;
        raw.aluop    = OP_R;
        case (funct)
          6'b010000, 6'b010010: ;
          6'b010001: begin raw.regwrite = 1'b0; raw.regdst = 1'b0; raw.hilowrite = 2'b10; end
          6'b010011: begin raw.regwrite = 1'b0; raw.regdst = 1'b0; raw.hilowrite = 2'b01; end
          6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
            raw.regwrite = 1'b0; raw.regdst = 1'b0; raw.hilowrite = 2'b11;
          end
          6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
          6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
          6'b000011, 6'b000100, 6'b000110, 6'b000111: ;
          default: bad_funct = 1'b1;
        endcase
      end
      6'b000001: begin
        case (rt)
          5'b00000, 5'b00001: begin raw.branch = 1'b1; raw.aluop = OP_BR; end
          5'b10000, 5'b10001: begin
            raw.branch = 1'b1; raw.regwrite = 1'b1; raw.bal = 1'b1; raw.aluop = OP_BR;
          end
          default: bad_op = 1'b1;
        endcase
      end
      6'b000010: raw.jump = 1'b1;
      6'b000011: begin raw.jump = 1'b1; raw.regwrite = 1'b1; raw.bal = 1'b1; end
      6'b000100, 6'b000101, 6'b000110, 6'b000111: begin raw.branch = 1'b1; raw.aluop = OP_BR; end
      6'b001000: begin raw.regwrite = 1'b1; raw.alusrc = 2'b01; raw.aluop = OP_ADDI;  end
      6'b001001: begin raw.regwrite = 1'b1; raw.alusrc = 2'b01; raw.aluop = OP_ADDIU; end
      6'b001010: begin raw.regwrite = 1'b1; raw.alusrc = 2'b01; raw.aluop = OP_SLTI;  end
      6'b001011: begin raw.regwrite = 1'b1; raw.alusrc = 2'b01; raw.aluop = OP_SLTIU; end
      6'b001100: begin raw.regwrite = 1'b1; raw.alusrc = 2'b10; raw.aluop = OP_ANDI;  end
      6'b001101: begin raw.regwrite = 1'b1; raw.alusrc = 2'b10; raw.aluop = OP_ORI;   end
      6'b001110: begin raw.regwrite = 1'b1; raw.alusrc = 2'b10; raw.aluop = OP_XORI;  end
      6'b001111: begin raw.regwrite = 1'b1; raw.alusrc = 2'b10; raw.aluop = OP_LUI;   end
      6'b100011: begin
        raw.regwrite = 1'b1; raw.memtoreg = 1'b1; raw.alusrc = 2'b01; raw.aluop = OP_MEM;
      end
      6'b101011: begin raw.memwrite = 1'b1; raw.alusrc = 2'b01; raw.aluop = OP_MEM; end
      default: begin raw.aluop = OP_NOP; bad_op = 1'b1; end
    endcase
  end

  // Unknown R-type functs only count as reserved when the exception is built in.
`ifdef RI_EXCEPT_EN
  assign dec_ri = bad_op | bad_funct;
`else
  logic unused_funct;
  assign unused_funct = bad_funct;
  assign dec_ri = 1'b0;
`endif
  assign dec = (bad_op | dec_ri) ? '0 : raw;

  assign hilo_user = (op == 6'b000000) &&
                     (funct inside {6'b010000, 6'b010001, 6'b010010, 6'b010011,
                                    6'b011000, 6'b011001, 6'b011010, 6'b011011});
  assign is_mul    = (op == 6'b000000) && (funct inside {6'b011000, 6'b011001});
  assign is_div    = (op == 6'b000000) && (funct inside {6'b011010, 6'b011011});

  assign md_busy  = (cnt != '0);
  assign id_ready = (!ex_valid || ex_ready) && !(md_busy && hilo_user);
  assign accept   = id_valid && id_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_q     <= '0;
      ex_ri    <= 1'b0;
      cnt      <= '0;
    end else begin
      if (flush)                     ex_valid <= 1'b0;
      else if (accept)               ex_valid <= 1'b1;
      else if (ex_valid && ex_ready) ex_valid <= 1'b0;

      if (accept) begin
        ex_q  <= dec;
        ex_ri <= dec_ri;
      end

      // Flush leaves the counter alone: the multiply/divide unit is already in flight.
      if (accept && is_mul)      cnt <= CNT_W'(MUL_CYCLES);
      else if (accept && is_div) cnt <= CNT_W'(DIV_CYCLES);
      else if (cnt != '0)        cnt <= cnt - 1'b1;
    end
  end

  assign ex_regwrite  = ex_q.regwrite;
  assign ex_regdst    = ex_q.regdst;
  assign ex_branch    = ex_q.branch;
  assign ex_memwrite  = ex_q.memwrite;
  assign ex_memtoreg  = ex_q.memtoreg;
  assign ex_jump      = ex_q.jump;
  assign ex_bal       = ex_q.bal;
  assign ex_alusrc    = ex_q.alusrc;
  assign ex_hilowrite = ex_q.hilowrite;
  assign ex_aluop     = ALUOP_W'(ex_q.aluop);

endmodule
